// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding, forwarding select codes and the forwarding priority helper.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    MCWAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  // Memory-stage result is younger than writeback, so it wins when both match.
  function automatic logic [1:0] fwd_pick(input logic m_hit, input logic w_hit);
    logic [1:0] sel;
    if (m_hit) begin
      sel = FWD_M;
    end else if (w_hit) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_event_counter.sv
// Free-running event counter: counts cycles with en high, wraps modulo 2^W.
module event_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles; reset clears the tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forwarding control for the decode/execute pipe.
// Resolves redirects (flush), multi-cycle ALU ops (countdown hold) and
// load-use hazards (one-cycle bubble). Optional build macro
// HAZARD_PERF_EN adds stall/flush event counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int M      = 4,
  parameter int MC_LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] srcA_D,
  input  logic [M-1:0] srcB_D,
  input  logic         useA_D,
  input  logic         useB_D,
  input  logic [M-1:0] srcA_E,
  input  logic [M-1:0] srcB_E,
  input  logic [M-1:0] regScr_E,
  input  logic [M-1:0] regScr_M,
  input  logic [M-1:0] regScr_W,
  input  logic         regw_E,
  input  logic         regw_M,
  input  logic         regw_W,
  input  logic         regmem_E,
  input  logic         regmem_M,
  input  logic         pcload_E,
  input  logic         branch_E,
  input  logic         flag_E,
  input  logic         ALUope_E,
  output logic         stall_F,
  output logic         stall_D,
  output logic         stall_E,
  output logic         flush_D,
  output logic         flush_E,
  output logic [1:0]   fwdA_E,
  output logic [1:0]   fwdB_E
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]  stall_cnt,
  output logic [31:0]  flush_cnt
`endif
);

  // The first stall cycle happens in RUN, so the countdown covers the rest.
  localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 2);

  state_t     state_r, state_nxt_s;
  logic [3:0] cnt_r, cnt_nxt_s;
  logic       redir_s, load_use_s;
  logic       stall_f_s, stall_d_s, stall_e_s, flush_d_s, flush_e_s;
  logic [1:0] fwd_a_s, fwd_b_s;

  assign redir_s    = pcload_E | (branch_E & flag_E);
  assign load_use_s = regmem_E & regw_E &
                      ((useA_D & (regScr_E == srcA_D)) | (useB_D & (regScr_E == srcB_D)));

  // Hazard priority and next-state decode: redirect > multi-cycle > load-use.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_f_s   = 1'b0;
    stall_d_s   = 1'b0;
    stall_e_s   = 1'b0;
    flush_d_s   = 1'b0;
    flush_e_s   = 1'b0;
    case (state_r)
      RUN: begin
        if (redir_s) begin
          flush_d_s = 1'b1;
          flush_e_s = 1'b1;
        end else if (ALUope_E) begin
          stall_f_s   = 1'b1;
          stall_d_s   = 1'b1;
          stall_e_s   = 1'b1;
          cnt_nxt_s   = MC_LOAD;
          state_nxt_s = MCWAIT;
        end else if (load_use_s) begin
          stall_f_s = 1'b1;
          stall_d_s = 1'b1;
          flush_e_s = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      MCWAIT: begin
        if (cnt_r != 4'd0) begin
          stall_f_s = 1'b1;
          stall_d_s = 1'b1;
          stall_e_s = 1'b1;
          cnt_nxt_s = cnt_r - 4'd1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = RUN;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Operand forwarding, independent of FSM state.
  always_comb begin
    fwd_a_s = fwd_pick(regw_M & ~regmem_M & (regScr_M == srcA_E), regw_W & (regScr_W == srcA_E));
    fwd_b_s = fwd_pick(regw_M & ~regmem_M & (regScr_M == srcB_E), regw_W & (regScr_W == srcB_E));
  end

  // Force all controls quiet while reset is held.
  always_comb begin
    if (!rst) begin
      stall_F = 1'b0;
      stall_D = 1'b0;
      stall_E = 1'b0;
      flush_D = 1'b0;
      flush_E = 1'b0;
      fwdA_E  = FWD_RF;
      fwdB_E  = FWD_RF;
    end else begin
      stall_F = stall_f_s;
      stall_D = stall_d_s;
      stall_E = stall_e_s;
      flush_D = flush_d_s;
      flush_E = flush_e_s;
      fwdA_E  = fwd_a_s;
      fwdB_E  = fwd_b_s;
    end
  end

  // FSM state and countdown; reset aborts any multi-cycle wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

`ifdef HAZARD_PERF_EN
  event_counter #(.W(32)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en    (stall_F),
    .count (stall_cnt)
  );

  event_counter #(.W(32)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en    (flush_E),
    .count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by a
// random stream, all compared against a cycle-occupancy reference model.
module tb_hazard_unit;

  localparam int M      = 4;
  localparam int MC_LAT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [M-1:0] srcA_D, srcB_D, srcA_E, srcB_E, regScr_E, regScr_M, regScr_W;
  logic         useA_D, useB_D, regw_E, regw_M, regw_W, regmem_E, regmem_M;
  logic         pcload_E, branch_E, flag_E, ALUope_E;
  logic         stall_F, stall_D, stall_E, flush_D, flush_E;
  logic [1:0]   fwdA_E, fwdB_E;
`ifdef HAZARD_PERF_EN
  logic [31:0]  stall_cnt, flush_cnt;
`endif

  hazard_unit #(.M(M), .MC_LAT(MC_LAT)) dut (
    .clk(clk), .rst(rst),
    .srcA_D(srcA_D), .srcB_D(srcB_D), .useA_D(useA_D), .useB_D(useB_D),
    .srcA_E(srcA_E), .srcB_E(srcB_E),
    .regScr_E(regScr_E), .regScr_M(regScr_M), .regScr_W(regScr_W),
    .regw_E(regw_E), .regw_M(regw_M), .regw_W(regw_W),
    .regmem_E(regmem_E), .regmem_M(regmem_M),
    .pcload_E(pcload_E), .branch_E(branch_E), .flag_E(flag_E), .ALUope_E(ALUope_E),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
    .flush_D(flush_D), .flush_E(flush_E), .fwdA_E(fwdA_E), .fwdB_E(fwdB_E)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  // Cycles of the current multi-cycle op still to come after this one.
  int busy = 0;
  int ref_stall_cnt = 0;
  int ref_flush_cnt = 0;
  logic e_stall, e_lu_stall, e_flush_d, e_flush_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [M-1:0] src);
    if (regw_M && !regmem_M && regScr_M == src) return 2'b10;
    if (regw_W && regScr_W == src) return 2'b01;
    return 2'b00;
  endfunction

  // Derive the expected controls from the hazard rules and compare.
  task automatic check_outputs(input string tag);
    logic redir, lu, mc_hold;
    logic [1:0] fa, fb;
    redir   = pcload_E || (branch_E && flag_E);
    lu      = regmem_E && regw_E &&
              ((useA_D && regScr_E == srcA_D) || (useB_D && regScr_E == srcB_D));
    mc_hold = 1'b0;
    e_stall = 1'b0; e_lu_stall = 1'b0; e_flush_d = 1'b0; e_flush_e = 1'b0;
    fa = ref_fwd(srcA_E);
    fb = ref_fwd(srcB_E);
    if (rst !== 1'b1) begin
      fa = 2'b00; fb = 2'b00;
    end else if (busy > 0) begin
      mc_hold = (busy > 1);
    end else if (redir) begin
      e_flush_d = 1'b1; e_flush_e = 1'b1;
    end else if (ALUope_E) begin
      mc_hold = 1'b1;
    end else if (lu) begin
      e_lu_stall = 1'b1; e_flush_e = 1'b1;
    end
    e_stall = mc_hold || e_lu_stall;
    chk({tag, ".stall_F"}, {31'd0, stall_F}, {31'd0, e_stall});
    chk({tag, ".stall_D"}, {31'd0, stall_D}, {31'd0, e_stall});
    chk({tag, ".stall_E"}, {31'd0, stall_E}, {31'd0, mc_hold});
    chk({tag, ".flush_D"}, {31'd0, flush_D}, {31'd0, e_flush_d});
    chk({tag, ".flush_E"}, {31'd0, flush_E}, {31'd0, e_flush_e});
    chk({tag, ".fwdA_E"}, {30'd0, fwdA_E}, {30'd0, fa});
    chk({tag, ".fwdB_E"}, {30'd0, fwdB_E}, {30'd0, fb});
`ifdef HAZARD_PERF_EN
    chk({tag, ".stall_cnt"}, stall_cnt, ref_stall_cnt);
    chk({tag, ".flush_cnt"}, flush_cnt, ref_flush_cnt);
`endif
  endtask

  // Check this cycle, take the clock edge, advance the model, return at negedge.
  task automatic step(input string tag);
    #1;
    check_outputs(tag);
    @(posedge clk);
    if (rst !== 1'b1) begin
      busy = 0; ref_stall_cnt = 0; ref_flush_cnt = 0;
    end else begin
      if (e_stall) ref_stall_cnt++;
      if (e_flush_e) ref_flush_cnt++;
      if (busy > 0) busy--;
      else if (!(pcload_E || (branch_E && flag_E)) && ALUope_E) busy = MC_LAT - 1;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    srcA_D = '0; srcB_D = '0; srcA_E = '0; srcB_E = '0;
    regScr_E = '0; regScr_M = '0; regScr_W = '0;
    useA_D = 1'b0; useB_D = 1'b0; regw_E = 1'b0; regw_M = 1'b0; regw_W = 1'b0;
    regmem_E = 1'b0; regmem_M = 1'b0; pcload_E = 1'b0; branch_E = 1'b0;
    flag_E = 1'b0; ALUope_E = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    quiet();
    @(negedge clk);
    step("reset");
    rst = 1'b1;
    step("idle");

    // Load-use on operand A: one bubble, then quiet.
    regmem_E = 1'b1; regw_E = 1'b1; regScr_E = 4'd3; srcA_D = 4'd3; useA_D = 1'b1;
    #1;
    chk("lu_stall_F", {31'd0, stall_F}, 32'd1);
    chk("lu_flush_E", {31'd0, flush_E}, 32'd1);
    step("loaduse");
    quiet();
    step("after_lu");

    // Taken branch flushes; untaken does not.
    branch_E = 1'b1; flag_E = 1'b1;
    step("br_taken");
`ifdef HAZARD_PERF_EN
    chk("perf_stall_cnt", stall_cnt, 32'd1);
    chk("perf_flush_cnt", flush_cnt, 32'd2);
`endif
    flag_E = 1'b0;
    step("br_untaken");
    quiet();

    // Multi-cycle op, twice back-to-back, then let it drain.
    ALUope_E = 1'b1;
    repeat (2 * MC_LAT) step("mc_b2b");
    ALUope_E = 1'b0;
    step("mc_done");

    // Forwarding priority M over W, load in M falls back to W.
    regw_M = 1'b1; regScr_M = 4'd5; regw_W = 1'b1; regScr_W = 4'd5; srcA_E = 4'd5;
    #1;
    chk("fwd_m", {30'd0, fwdA_E}, 32'd2);
    step("fwd_m");
    regmem_M = 1'b1;
    #1;
    chk("fwd_w", {30'd0, fwdA_E}, 32'd1);
    step("fwd_w");
    quiet();

    // Reset mid-wait aborts the hold.
    ALUope_E = 1'b1;
    step("mc_start");
    ALUope_E = 1'b0;
    #1;
    check_outputs("mc_wait");
    rst = 1'b0;
    #1;
    chk("rst_mid_stall", {31'd0, stall_F}, 32'd0);
    step("rst_mid");
    rst = 1'b1;
    step("post_rst");

    // Random traffic over a small register pool to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      srcA_D = 4'($urandom_range(0, 3)); srcB_D = 4'($urandom_range(0, 3));
      srcA_E = 4'($urandom_range(0, 3)); srcB_E = 4'($urandom_range(0, 3));
      regScr_E = 4'($urandom_range(0, 3)); regScr_M = 4'($urandom_range(0, 3));
      regScr_W = 4'($urandom_range(0, 3));
      useA_D = 1'($urandom); useB_D = 1'($urandom);
      regw_E = 1'($urandom); regw_M = 1'($urandom); regw_W = 1'($urandom);
      regmem_E = 1'($urandom); regmem_M = 1'($urandom);
      pcload_E = ($urandom_range(0, 7) == 0);
      branch_E = 1'($urandom); flag_E = ($urandom_range(0, 3) == 0);
      ALUope_E = ($urandom_range(0, 7) == 0);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller that drives the control side of the decode/execute pipeline registers: stall enables for fetch, decode and execute; flush for decode and execute; and forwarding selects for the execute operands. It watches the decoded instruction, the instruction in execute, and the destinations in memory and writeback. It resolves three hazards:
- load-use, by inserting a bubble;
- taken branch or PC load, by flushing;
- multi-cycle ALU operations, by holding the pipe with a countdown FSM.

## Interface
Parameters:
- M, 4, register address width
- MC_LAT, 3, total cycles a multi-cycle ALU op (ALUope_E=1) occupies execute; legal range 2..16

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- srcA_D, srcB_D  in  M  source register addresses of instruction in decode
- useA_D, useB_D  in  1  decode instruction actually reads srcA_D / srcB_D
- srcA_E, srcB_E  in  M  source register addresses of instruction in execute
- regScr_E, regScr_M, regScr_W  in  M  destination register per stage
- regw_E, regw_M, regw_W  in  1  register write enable per stage
- regmem_E, regmem_M  in  1  instruction is a load
- pcload_E, branch_E, flag_E  in  1  PC load / branch / branch condition true, in execute
- ALUope_E  in  1  execute holds a multi-cycle ALU op
- stall_F, stall_D, stall_E  out  1  hold the respective pipeline register
- flush_D, flush_E  out  1  clear the respective pipeline register (drives flush_E of the D/E register)
- fwdA_E, fwdB_E  out  2  operand select: 00 register file, 10 from M, 01 from W
- stall_cnt, flush_cnt  out  32  event counters (only with HAZARD_PERF_EN)

## Operation
- FSM states: RUN, MCWAIT. A 4-bit down-counter `cnt` is used in MCWAIT.
- Taken redirect: `redir = pcload_E | (branch_E & flag_E)`. When `redir` is set in RUN, assert flush_D=1 and flush_E=1 in the same cycle. No stall. Highest priority.
- Multi-cycle op: in RUN with ALUope_E=1 and !redir:
  - assert stall_F, stall_D, stall_E;
  - load cnt = MC_LAT-2;
  - go to MCWAIT.
- In MCWAIT:
  - cnt != 0: keep all three stalls asserted and decrement cnt.
  - cnt == 0: deassert the stalls and return to RUN.
  - Load-use and redirect detection is ignored in MCWAIT.
- Load-use: in RUN with no redirect and no multi-cycle op, check `regmem_E & regw_E & ((useA_D & regScr_E==srcA_D) | (useB_D & regScr_E==srcB_D))`. If true, assert stall_F=1, stall_D=1, flush_E=1 for that cycle only.
- Forwarding for operand A (B is identical with srcB_E):
  - 10 if `regw_M & !regmem_M & regScr_M==srcA_E`;
  - otherwise 01 if `regw_W & regScr_W==srcA_E`;
  - otherwise 00.
  - M takes priority over W.
  - Forwarding is evaluated in every state.
- Register 0 has no special case; every address compares.

## Timing
- All stall, flush and fwd outputs are combinational from state, cnt and the current inputs. There is no added latency.
- A multi-cycle op holds execute for exactly MC_LAT cycles, with stall asserted MC_LAT-1 of them. Back-to-back multi-cycle ops each get the full MC_LAT.
- A load-use stall always lasts one cycle. On the following cycle the load is in M and the consumer is in execute still stalled? No: the consumer is in decode re-evaluated against a bubble in E, so no second stall occurs.
- While rst=0:
  - state=RUN, cnt=0;
  - every stall, flush and fwd output is forced to 0;
  - counters are 0.
- Reset asserted during MCWAIT aborts the wait immediately.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments on every cycle with stall_F=1;
  - flush_cnt increments on every cycle with flush_E=1 (covers both redirect and load-use bubble);
  - both are 32-bit and wrap modulo 2^32.
- HAZARD_PERF_EN undefined: the counters and their ports are absent.

## Structure
- Shared package hazard_pkg holds:
  - the state enum {RUN, MCWAIT};
  - forwarding select constants FWD_RF=2'b00, FWD_M=2'b10, FWD_W=2'b01.
- One sub-module, event_counter (32-bit, enable, async active-low reset, wrap). It is instantiated twice under HAZARD_PERF_EN.

## Test plan
- Load r3 in E (regmem_E=1, regw_E=1, regScr_E=3), decode reads srcA_D=3 with useA_D=1 -> one cycle of stall_F=stall_D=flush_E=1, then all 0.
- branch_E=1, flag_E=1 -> flush_D=flush_E=1 that cycle. With flag_E=0 -> no flush.
- ALUope_E=1 with MC_LAT=3 -> stalls high for 2 cycles, low on the 3rd, FSM back in RUN. Repeat back-to-back -> 2 more stall cycles.
- regScr_M=5 (regw_M=1), regScr_W=5 (regw_W=1), srcA_E=5 -> fwdA_E=10. Set regmem_M=1 -> fwdA_E=01.
- Drop rst mid-MCWAIT -> stalls 0 immediately. After release, ALUope_E=0 -> no stall.
- HAZARD_PERF_EN: a load-use plus a branch flush -> stall_cnt=1, flush_cnt=2.
